// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and fetch constants for the fetch sequencer
package fetch_pkg;
   typedef enum logic [1:0] {IDLE, REQ, HOLD, SQUASH} fetchState_t;
   localparam int INST_BYTES = 4;
   localparam int WORD_SHIFT = 2;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory req/ack and decode valid/ready bundle
interface fetch_sequencer_if #(parameter int ADDR_W = 32);
   logic              imemReq;
   logic [ADDR_W-1:0] imemAddr;
   logic              imemAck;
   logic [31:0]       imemData;
   logic              instValid;
   logic [31:0]       instruction;
   logic [ADDR_W-1:0] instPc;
   logic              instReady;
   modport master (output imemReq, imemAddr, instValid, instruction, instPc, input imemAck, imemData, instReady);
   modport slave (input imemReq, imemAddr, instValid, instruction, instPc, output imemAck, imemData, instReady);
endinterface

// File: rtl/fetch_sequencer_branch_target_unit.sv
// branch_target_unit: resolves branch direction and word-offset target, shared with execute
module branch_target_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              brValid,
   input  logic              branchFlag,
   input  logic              unconditionalBranchFlag,
   input  logic              zeroFlag,
   input  logic [ADDR_W-1:0] brPc,
   input  logic [ADDR_W-1:0] pcOffsetFilled,
   output logic              taken,
   output logic [ADDR_W-1:0] target
);
   // CBZ-style conditional or unconditional; target wraps modulo 2^ADDR_W
   always_comb begin
      taken  = brValid & ((branchFlag & zeroFlag) | unconditionalBranchFlag);
      target = brPc + (pcOffsetFilled << WORD_SHIFT);
   end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and one-deep fetch buffer; FETCH_STATS_EN adds fetch/squash counters
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clock,
   input  logic              resetN,
   input  logic              brValid,
   input  logic              branchFlag,
   input  logic              unconditionalBranchFlag,
   input  logic              zeroFlag,
   input  logic [ADDR_W-1:0] brPc,
   input  logic [ADDR_W-1:0] pcOffsetFilled,
   fetch_sequencer_if.master bus,
   output logic [31:0]       fetchCount,
   output logic [31:0]       squashCount
);
   fetchState_t       state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] squashAddr;
   logic              taken;
   logic [ADDR_W-1:0] target;

   branch_target_unit #(.ADDR_W(ADDR_W)) btu (
      .brValid(brValid),
      .branchFlag(branchFlag),
      .unconditionalBranchFlag(unconditionalBranchFlag),
      .zeroFlag(zeroFlag),
      .brPc(brPc),
      .pcOffsetFilled(pcOffsetFilled),
      .taken(taken),
      .target(target)
   );

   // request stays up at the stale address in SQUASH since it cannot be withdrawn; valid is killed combinationally by a redirect
   always_comb begin
      bus.imemReq   = (state == REQ) | (state == SQUASH);
      bus.imemAddr  = (state == SQUASH) ? squashAddr : pc;
      bus.instValid = (state == HOLD) & ~taken;
   end

   // fetch FSM: pc redirect, buffer capture and wrong-path discard
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state           <= IDLE;
         pc              <= RESET_PC;
         squashAddr      <= '0;
         bus.instruction <= '0;
         bus.instPc      <= '0;
      end else begin
         case (state)
            IDLE: begin
               pc    <= taken ? target : pc;
               state <= REQ;
            end
            REQ: begin
               if (taken) begin
                  pc <= target;
                  if (!bus.imemAck) begin
                     squashAddr <= pc;
                     state      <= SQUASH;
                  end
               end else if (bus.imemAck) begin
                  bus.instruction <= bus.imemData;
                  bus.instPc      <= pc;
                  pc              <= pc + ADDR_W'(INST_BYTES);
                  state           <= HOLD;
               end
            end
            HOLD: begin
               if (taken) begin
                  pc    <= target;
                  state <= REQ;
               end else if (bus.instReady) begin
                  state <= REQ;
               end
            end
            SQUASH: begin
               if (taken) pc <= target;
               if (bus.imemAck) state <= REQ;
            end
         endcase
      end
   end

`ifdef FETCH_STATS_EN
   logic deliver;
   logic drop;
   assign deliver = bus.instValid & bus.instReady;
   assign drop    = (taken & ((state == HOLD) | ((state == REQ) & bus.imemAck))) | ((state == SQUASH) & bus.imemAck);

   // wrapping counts of delivered instructions and discarded buffers/responses
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         fetchCount  <= '0;
         squashCount <= '0;
      end else begin
         fetchCount  <= fetchCount + 32'(deliver);
         squashCount <= squashCount + 32'(drop);
      end
   end
`else
   assign fetchCount  = '0;
   assign squashCount = '0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vectors for the fetch sequencer with a zero-wait gated memory model
module tb_fetch_sequencer;
   localparam logic [31:0] KEY = 32'h5A5A_0000;
`ifdef FETCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        resetN;
   logic        brValid, branchFlag, unconditionalBranchFlag, zeroFlag;
   logic [31:0] brPc, pcOffsetFilled;
   logic [31:0] fetchCount, squashCount;
   logic        ackEn;
   int          vecCount = 0;
   int          missCount = 0;

   fetch_sequencer_if #(.ADDR_W(32)) bus ();

   fetch_sequencer dut (
      .clock(clock),
      .resetN(resetN),
      .brValid(brValid),
      .branchFlag(branchFlag),
      .unconditionalBranchFlag(unconditionalBranchFlag),
      .zeroFlag(zeroFlag),
      .brPc(brPc),
      .pcOffsetFilled(pcOffsetFilled),
      .bus(bus),
      .fetchCount(fetchCount),
      .squashCount(squashCount)
   );

   always #5 clock = ~clock;

   assign bus.imemAck  = ackEn & bus.imemReq;
   assign bus.imemData = bus.imemAddr ^ KEY;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecCount++;
      if (got !== exp) begin
         missCount++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic branch(input logic u, input logic b, input logic z, input logic [31:0] pcIn, input logic [31:0] off);
      brValid                 = 1'b1;
      unconditionalBranchFlag = u;
      branchFlag              = b;
      zeroFlag                = z;
      brPc                    = pcIn;
      pcOffsetFilled          = off;
   endtask

   task automatic noBranch();
      brValid                 = 1'b0;
      unconditionalBranchFlag = 1'b0;
      branchFlag              = 1'b0;
      zeroFlag                = 1'b0;
      brPc                    = '0;
      pcOffsetFilled          = '0;
   endtask

   initial begin
      resetN        = 1'b0;
      ackEn         = 1'b1;
      bus.instReady = 1'b1;
      noBranch();
      step();
      step();
      check("rst imemReq", 32'(bus.imemReq), 0);
      check("rst instValid", 32'(bus.instValid), 0);
      check("rst instruction", bus.instruction, 0);
      check("rst instPc", bus.instPc, 0);
      check("rst fetchCount", fetchCount, 0);
      check("rst squashCount", squashCount, 0);
      resetN = 1'b1;
      check("idle imemReq", 32'(bus.imemReq), 0);
      step();
      check("first req", 32'(bus.imemReq), 1);
      check("first addr", bus.imemAddr, 32'h0);
      step();
      check("first valid", 32'(bus.instValid), 1);
      check("first instPc", bus.instPc, 32'h0);
      check("first instruction", bus.instruction, 32'h5A5A_0000);
      check("hold no req", 32'(bus.imemReq), 0);
      for (int i = 1; i < 4; i++) begin
         step();
         check("seq gap valid", 32'(bus.instValid), 0);
         check("seq addr", bus.imemAddr, 32'(4 * i));
         step();
         check("seq valid", 32'(bus.instValid), 1);
         check("seq instPc", bus.instPc, 32'(4 * i));
         check("seq instruction", bus.instruction, KEY | 32'(4 * i));
      end
      bus.instReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall valid", 32'(bus.instValid), 1);
         check("stall instPc", bus.instPc, 32'h0C);
         check("stall instruction", bus.instruction, 32'h5A5A_000C);
         check("stall imemReq", 32'(bus.imemReq), 0);
      end
      branch(1'b1, 1'b0, 1'b0, 32'h0C, 32'hFFFF_FFFE);
      #1;
      check("hold redirect kills valid", 32'(bus.instValid), 0);
      step();
      noBranch();
      check("back branch addr", bus.imemAddr, 32'h04);
      check("back branch req", 32'(bus.imemReq), 1);
      bus.instReady = 1'b1;
      step();
      check("refetch instPc", bus.instPc, 32'h04);
      step();
      check("after refetch addr", bus.imemAddr, 32'h08);
      check("stats fetch 4", fetchCount, STATS ? 32'd4 : 32'd0);
      check("stats squash 1", squashCount, STATS ? 32'd1 : 32'd0);
      branch(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
      step();
      noBranch();
      ackEn = 1'b0;
      check("ack+taken addr", bus.imemAddr, 32'h20);
      check("ack+taken discarded", 32'(bus.instValid), 0);
      check("ack+taken req", 32'(bus.imemReq), 1);
      branch(1'b0, 1'b1, 1'b0, 32'h1C, 32'h4);
      step();
      check("cbz not taken addr", bus.imemAddr, 32'h20);
      branch(1'b0, 1'b1, 1'b1, 32'h1C, 32'h4);
      step();
      noBranch();
      check("squash req", 32'(bus.imemReq), 1);
      check("squash old addr 1", bus.imemAddr, 32'h20);
      step();
      check("squash old addr 2", bus.imemAddr, 32'h20);
      step();
      check("squash old addr 3", bus.imemAddr, 32'h20);
      ackEn = 1'b1;
      step();
      check("post squash addr", bus.imemAddr, 32'h2C);
      check("squash data discarded", 32'(bus.instValid), 0);
      step();
      check("target instPc", bus.instPc, 32'h2C);
      check("target instruction", bus.instruction, 32'h5A5A_002C);
      branch(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h3);
      #1;
      check("wrap redirect kills valid", 32'(bus.instValid), 0);
      step();
      noBranch();
      check("wrap target addr", bus.imemAddr, 32'h04);
      check("stats fetch held", fetchCount, STATS ? 32'd4 : 32'd0);
      check("stats squash 4", squashCount, STATS ? 32'd4 : 32'd0);
      ackEn = 1'b0;
      branch(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
      step();
      noBranch();
      check("pre-reset squash req", 32'(bus.imemReq), 1);
      check("pre-reset squash addr", bus.imemAddr, 32'h04);
      #2;
      resetN = 1'b0;
      #1;
      check("async rst imemReq", 32'(bus.imemReq), 0);
      check("async rst fetchCount", fetchCount, 0);
      check("async rst squashCount", squashCount, 0);
      check("async rst instPc", bus.instPc, 0);
      step();
      resetN = 1'b1;
      ackEn  = 1'b1;
      check("re-idle imemReq", 32'(bus.imemReq), 0);
      step();
      check("restart req", 32'(bus.imemReq), 1);
      check("restart addr", bus.imemAddr, 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end
endmodule
